inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 101 ++++++++++
 tb/tb_inst_fetch.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time, holds the
// returned instruction for decode, and handles execute-stage redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        squash;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  assign target_aligned = redirect_target & 32'hFFFF_FFFC;
  assign pc_plus4       = pc + 32'd4;

  // A redirect seen while a request is outstanding cannot cancel it, so the
  // target is parked in pc_next and the returning word is dropped on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC_ALIGNED;
      pc_next    <= 32'd0;
      squash     <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC_ALIGNED;
      inst_valid <= 1'b0;
      inst_code  <= 32'd0;
      inst_pc    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc        <= target_aligned;
            imem_addr <= target_aligned;
          end else begin
            imem_addr <= pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (squash || redirect_valid) begin
              pc        <= redirect_valid ? target_aligned : pc_next;
              imem_addr <= redirect_valid ? target_aligned : pc_next;
              squash    <= 1'b0;
            end else begin
              inst_code  <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              imem_req   <= 1'b0;
              state      <= HOLD;
            end
          end else if (redirect_valid) begin
            pc_next <= target_aligned;
            squash  <= 1'b1;
          end
        end
        HOLD: begin
          // Redirect wins over a transfer: the held instruction is squashed.
          if (redirect_valid) begin
            pc         <= target_aligned;
            imem_addr  <= target_aligned;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end else if (inst_ready) begin
            pc         <= pc_plus4;
            imem_addr  <= pc_plus4;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a bench-side memory model pushes expected
// instruction/pc pairs to a scoreboard, popped when the DUT presents them.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_ack, inst_valid, inst_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, inst_code, inst_pc, redirect_target;

  logic        reset2, imem_req2, imem_ack2, inst_valid2, inst_ready2;
  logic [31:0] imem_addr2, imem_rdata2, inst_code2, inst_pc2;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] fetch_pc;

  inst_fetch u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_code(inst_code), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .inst_valid(inst_valid2),
    .inst_code(inst_code2), .inst_pc(inst_pc2), .inst_ready(inst_ready2),
    .redirect_valid(1'b0), .redirect_target(32'd0)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0093;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic rv, input logic [31:0] tgt, input logic rdy);
    imem_ack        = ack;
    imem_rdata      = rdata;
    redirect_valid  = rv;
    redirect_target = tgt;
    inst_ready      = rdy;
  endtask

  // Acks the current request with the model's word for addr and queues it.
  task automatic serve(input logic [31:0] addr);
    applyStimulus(1'b1, mem(addr), 1'b0, 32'd0, 1'b1);
    e.code = mem(addr);
    e.pc   = addr;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
    tick();
    tick();
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_valid !== 1'b0 ||
        inst_code !== 32'd0 || inst_pc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got req=%b addr=%h valid=%b code=%h pc=%h, expected 0/0/0/0/0",
               imem_req, imem_addr, inst_valid, inst_code, inst_pc);
    end
    vectors++;
    if (imem_addr2 !== 32'hFFFF_FFFC || imem_req2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state_wrap: got req=%b addr=%h, expected 0/fffffffc", imem_req2, imem_addr2);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_cycle: got req=%b, expected 0", imem_req);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL first_request: got req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    int xfers = 0;
    int last  = -1;
    fetch_pc = 32'd0;
    for (int cyc = 0; cyc < 20 && xfers < 3; cyc++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      if (inst_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL stream_unexpected: got valid pc=%h, expected no instruction", inst_pc);
        end else begin
          e = sb.pop_front();
          if (inst_code !== e.code || inst_pc !== e.pc) begin
            miscompares++;
            $display("[TB] FAIL stream_data: got code=%h pc=%h, expected code=%h pc=%h",
                     inst_code, inst_pc, e.code, e.pc);
          end
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 2) begin
            miscompares++;
            $display("[TB] FAIL stream_rate: got %0d cycles between transfers, expected 2", cyc - last);
          end
        end
        last = cyc;
        xfers++;
        fetch_pc = fetch_pc + 32'd4;
      end else if (imem_req) begin
        vectors++;
        if (imem_addr !== fetch_pc) begin
          miscompares++;
          $display("[TB] FAIL stream_addr: got addr=%h, expected %h", imem_addr, fetch_pc);
        end
        serve(fetch_pc);
      end
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (xfers != 3) begin
      miscompares++;
      $display("[TB] FAIL stream_timeout: got %0d transfers, expected 3", xfers);
    end
  endtask

  task automatic test_stall();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C) begin
      miscompares++;
      $display("[TB] FAIL stall_req: got req=%b addr=%h, expected 1/0000000c", imem_req, imem_addr);
    end
    serve(32'h0000_000C);
    inst_ready = 1'b0;
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_code !== mem(32'h0000_000C) ||
          inst_pc !== 32'h0000_000C) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: cycle %0d got valid=%b req=%b code=%h pc=%h, expected 1/0/%h/0000000c",
                 i, inst_valid, imem_req, inst_code, inst_pc, mem(32'h0000_000C));
      end
      tick();
    end
    inst_ready = 1'b1;
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_redirect_hold();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010) begin
      miscompares++;
      $display("[TB] FAIL rdh_req: got req=%b addr=%h, expected 1/00000010", imem_req, imem_addr);
    end
    applyStimulus(1'b1, mem(32'h0000_0010), 1'b0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0103, 1'b1);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0010) begin
      miscompares++;
      $display("[TB] FAIL rdh_hold: got valid=%b pc=%h, expected 1/00000010", inst_valid, inst_pc);
    end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      miscompares++;
      $display("[TB] FAIL rdh_target: got valid=%b req=%b addr=%h, expected 0/1/00000100",
               inst_valid, imem_req, imem_addr);
    end
    serve(32'h0000_0100);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL rdh_first_valid: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_redirect_req();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0202, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0104 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rdr_held: cycle %0d got req=%b addr=%h valid=%b, expected 1/00000104/0",
                 i, imem_req, imem_addr, inst_valid);
      end
      tick();
    end
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      miscompares++;
      $display("[TB] FAIL rdr_discard: got valid=%b req=%b addr=%h, expected 0/1/00000200",
               inst_valid, imem_req, imem_addr);
    end
    serve(32'h0000_0200);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL rdr_first_valid: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0501, 1'b1);
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (imem_addr !== 32'h0000_0204) begin
      miscompares++;
      $display("[TB] FAIL b2b_held: got addr=%h, expected 00000204", imem_addr);
    end
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0600, 1'b1);
    vectors++;
    if (imem_addr !== 32'h0000_0500 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_last_target: got addr=%h valid=%b, expected 00000500/0", imem_addr, inst_valid);
    end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (imem_addr !== 32'h0000_0600 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_same_cycle: got addr=%h valid=%b req=%b, expected 00000600/0/1",
               imem_addr, inst_valid, imem_req);
    end
    serve(32'h0000_0600);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL b2b_valid: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_reset_midreq();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_code !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midreq_reset: got valid=%b req=%b addr=%h code=%h, expected 0/0/0/0",
               inst_valid, imem_req, imem_addr, inst_code);
    end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreq_restart: got req=%b addr=%h valid=%b, expected 1/00000000/0",
               imem_req, imem_addr, inst_valid);
    end
    serve(32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL midreq_valid: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_idle_redirect();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0707, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0704) begin
      miscompares++;
      $display("[TB] FAIL idle_redirect: got req=%b addr=%h, expected 1/00000704", imem_req, imem_addr);
    end
    serve(32'h0000_0704);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    vectors++;
    e = sb.pop_front();
    if (inst_valid !== 1'b1 || inst_code !== e.code || inst_pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL idle_redirect_valid: got valid=%b code=%h pc=%h, expected 1/%h/%h",
               inst_valid, inst_code, inst_pc, e.code, e.pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    tick();
    vectors++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("[TB] FAIL wrap_first_req: got req=%b addr=%h, expected 1/fffffffc", imem_req2, imem_addr2);
    end
    imem_ack2   = 1'b1;
    imem_rdata2 = mem(32'hFFFF_FFFC);
    inst_ready2 = 1'b1;
    tick();
    imem_ack2 = 1'b0;
    vectors++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'hFFFF_FFFC || inst_code2 !== mem(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("[TB] FAIL wrap_valid: got valid=%b pc=%h code=%h, expected 1/fffffffc/%h",
               inst_valid2, inst_pc2, inst_code2, mem(32'hFFFF_FFFC));
    end
    tick();
    vectors++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0000_0000) begin
      miscompares++;
      $display("[TB] FAIL wrap_next: got req=%b addr=%h, expected 1/00000000", imem_req2, imem_addr2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    reset2      = 1'b1;
    imem_ack2   = 1'b0;
    imem_rdata2 = 32'd0;
    inst_ready2 = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_hold();
    test_redirect_req();
    test_back_to_back();
    test_reset_midreq();
    test_idle_redirect();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
